// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants for the ID/EX pipeline register stage
package id_ex_stage_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1111;

    localparam int IDC_W          = 5;
    localparam int IDC_REG_WRITE  = 4;
    localparam int IDC_MEM_READ   = 3;
    localparam int IDC_MEM_WRITE  = 2;
    localparam int IDC_MEM_TO_REG = 1;
    localparam int IDC_ALU_SRC    = 0;

    localparam int EXC_W          = 4;
    localparam int EXC_REG_WRITE  = 3;
    localparam int EXC_MEM_READ   = 2;
    localparam int EXC_MEM_WRITE  = 1;
    localparam int EXC_MEM_TO_REG = 0;

    // $zero is hard-wired, so a write to it must never be forwarded
    function automatic logic fwd_hit(input logic we, input logic [RW-1:0] rd,
                                     input logic [RW-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// rtl/id_ex_stage_fwd_unit.sv - per-operand priority forwarding mux
module fwd_unit #(
    parameter int DW = id_ex_stage_pkg::DW
) (
    input  logic [4:0]    src_reg,
    input  logic [DW-1:0] reg_data,
    input  logic          exm_we,
    input  logic [4:0]    exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd_data
);
    import id_ex_stage_pkg::*;

    // EX/MEM holds the younger result, so it beats MEM/WB on a double match
    always_comb begin
        fwd_data = reg_data;
        if (fwd_hit(exm_we, exm_rd, src_reg)) begin
            fwd_data = exm_data;
        end else if (fwd_hit(wb_we, wb_rd, src_reg)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module id_ex_stage #(
    parameter int DW = id_ex_stage_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_wreg,
    input  logic [3:0]    id_alu_ctrl,
    input  logic [4:0]    id_ctrl,
    input  logic          exm_we,
    input  logic [4:0]    exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] ex_data1,
    output logic [DW-1:0] ex_data2,
    output logic [5:0]    ex_shamt,
    output logic [3:0]    ex_alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [4:0]    ex_wreg,
    output logic [3:0]    ex_ctrl,
    output logic          ex_valid,
    output logic          load_use
);
    import id_ex_stage_pkg::*;

    logic [DW-1:0]    rs_data_d, rs_data_q;
    logic [DW-1:0]    rt_data_d, rt_data_q;
    logic [DW-1:0]    imm_d, imm_q;
    logic [4:0]       shamt_d, shamt_q;
    logic [4:0]       rs_d, rs_q;
    logic [4:0]       rt_d, rt_q;
    logic [4:0]       wreg_d, wreg_q;
    logic [3:0]       alu_ctrl_d, alu_ctrl_q;
    logic [IDC_W-1:0] ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [DW-1:0]    fwd_a_data, fwd_b_data;

    // A bubble is all-zero: no control effects, and ALU opcode 0000 is SLL
    always_comb begin
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wreg_d     = wreg_q;
        alu_ctrl_d = alu_ctrl_q;
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        if (flush) begin
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            shamt_d    = '0;
            rs_d       = '0;
            rt_d       = '0;
            wreg_d     = '0;
            alu_ctrl_d = ALU_SLL;
            ctrl_d     = '0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            rs_d       = id_rs;
            rt_d       = id_rt;
            wreg_d     = id_wreg;
            alu_ctrl_d = id_alu_ctrl;
            ctrl_d     = id_ctrl;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            alu_ctrl_q <= ALU_SLL;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wreg_q     <= wreg_d;
            alu_ctrl_q <= alu_ctrl_d;
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
        end
    end

    fwd_unit #(.DW(DW)) u_fwd_a (
        .src_reg  (rs_q),
        .reg_data (rs_data_q),
        .exm_we   (exm_we),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (fwd_a_data)
    );

    fwd_unit #(.DW(DW)) u_fwd_b (
        .src_reg  (rt_q),
        .reg_data (rt_data_q),
        .exm_we   (exm_we),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (fwd_b_data)
    );

    assign ex_data1      = fwd_a_data;
    assign ex_data2      = ctrl_q[IDC_ALU_SRC] ? imm_q : fwd_b_data;
    assign ex_store_data = fwd_b_data;
    assign ex_shamt      = {1'b0, shamt_q};
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_wreg       = wreg_q;
    assign ex_ctrl       = ctrl_q[IDC_W-1:IDC_W-EXC_W];
    assign ex_valid      = valid_q;

    // Raised regardless of stall so the hazard logic keeps ID frozen until the load advances
    assign load_use = valid_q && ctrl_q[IDC_MEM_READ] && (wreg_q != 5'd0)
                      && ((wreg_q == id_rs) || (wreg_q == id_rt));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DW, 32, datapath width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold all EX-side registers unchanged.
REQ-005 flush  in  1  load a bubble instead of ID contents.
REQ-006 id_rs_data / id_rt_data  in  DW each  register-file read data.
REQ-007 id_imm  in  DW  already-extended immediate.
REQ-008 id_shamt  in  5  shift amount field.
REQ-009 id_rs / id_rt / id_wreg  in  5 each  source and selected destination register numbers.
REQ-010 id_alu_ctrl  in  4  ALU opcode (package encoding).
REQ-011 id_ctrl  in  5  {reg_write, mem_read, mem_write, mem_to_reg, alu_src}.
REQ-012 exm_we / exm_rd / exm_data  in  1/5/DW  EX/MEM forwarding source.
REQ-013 wb_we / wb_rd / wb_data  in  1/5/DW  MEM/WB forwarding source.
REQ-014 ex_data1 / ex_data2  out  DW each  ALU operands after forwarding and alu_src select.
REQ-015 ex_shamt  out  6  zero-extended shift amount to ALU.
REQ-016 ex_alu_ctrl  out  4  registered ALU opcode.
REQ-017 ex_store_data  out  DW  forwarded rt value for stores.
REQ-018 ex_wreg / ex_ctrl / ex_valid  out  5/4/1  destination, {reg_write, mem_read, mem_write, mem_to_reg}, non-bubble flag.
REQ-019 load_use  out  1  combinational stall request to ID/hazard logic.

Function
REQ-020 Each cycle with rst=0, stall=0, flush=0: register all id_* fields, ex_valid<=1; fields appear on outputs 1 cycle later.
REQ-021 stall=1, flush=0: every register holds; forwarding muxes keep evaluating against current exm/wb inputs.
REQ-022 flush=1: load bubble -- ex_ctrl=0, ex_valid=0, ex_wreg=0, alu_ctrl=4'b0000 (SLL), shamt=0, rs=rt=0, data/imm=0; flush overrides stall.
REQ-023 Operand A: exm_we && exm_rd!=0 && exm_rd==rs_q -> exm_data; else wb_we && wb_rd!=0 && wb_rd==rs_q -> wb_data; else rs_data_q.
REQ-024 Operand B source identical rule on rt_q; EX/MEM always wins over MEM/WB on simultaneous match.
REQ-025 Register 0 never forwarded; rs_q/rt_q==0 always yields registered data (0 from regfile).
REQ-026 ex_data2 = alu_src_q ? imm_q : forwarded B; ex_store_data = forwarded B regardless of alu_src.
REQ-027 Forwarding and alu_src select are purely combinational on registered state (zero added latency).
REQ-028 load_use = ex_valid && mem_read_q && wreg_q!=0 && (wreg_q==id_rs || wreg_q==id_rt); asserted independent of stall.
REQ-029 ex_shamt = {1'b0, shamt_q}; widths never truncated; no arithmetic performed in this block.

Reset
REQ-030 rst=1 on a clock edge loads the bubble of REQ-022; rst overrides stall and flush.
REQ-031 After reset all outputs are 0 (ex_data1/ex_data2 = 0 unless exm/wb forwarding disabled, which holds since rs_q=rt_q=0), load_use=0.

Structure
REQ-032 Shared package holds: ALU opcode constants (ADD 0001, SUB 0010, AND 0100, OR 0101, XOR 0110, LUI 0111, SLT 1010, SLL 0000, SRL 1111), id_ctrl/ex_ctrl bit indices, DW, register-number width 5.
REQ-033 One sub-module fwd_unit: per-operand priority forwarding mux (REQ-023..025), instantiated twice.

Verification
REQ-034 Plain: id_rs_data=5, id_rt_data=7, alu_ctrl=0001, alu_src=0, no fwd -> next cycle ex_data1=5, ex_data2=7, ex_valid=1.
REQ-035 Double match: rs_q=rt_q=8, exm_we=1 exm_rd=8 exm_data=0x11, wb_we=1 wb_rd=8 wb_data=0x22 -> ex_data1=0x11, ex_store_data=0x11; with exm_we=0 -> 0x22.
REQ-036 $zero: rs_q=0, exm_we=1, exm_rd=0, exm_data=0xFF -> ex_data1=0.
REQ-037 Load-use: registered lw with wreg=9, mem_read=1; next ID id_rt=9 -> load_use=1; id_rs=id_rt=3 -> load_use=0.
REQ-038 stall=1 for 3 cycles with changing id_* -> outputs unchanged; stall=1 and flush=1 -> bubble (ex_valid=0, ex_ctrl=0).
REQ-039 rst=1 mid-stream with stall=1 -> next cycle all registered outputs 0, alu_ctrl=0000, load_use=0.
